decode_issue_ctrl: RTL
======================

# decode_issue_ctrl

Multi-cycle issue controller between instruction fetch and the 16-bit datapath (register file, ALU, data memory). It accepts one 32-bit instruction at a time over a valid/ready handshake and decodes the 6-bit opcode and register/immediate/address fields. It then sequences register reads, ALU or multiplier execution, data-memory access and register write-back through a small state machine. Only one instruction is in flight at any time; there is no pipelining.

## Interface
- MUL_LAT, 4: multiplier latency in cycles; legal range 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  fetch presents an instruction.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  32  instruction word.
  - Opcode is [31:26], Rdst2 is [25:21], Rdst1 is [20:16], Rsrc2 is [9:5], Rsrc1 is [4:0], imm16 is [15:0].
  - The load address field is [7:0]. The store address field is [25:18].
- rf_ra1  out  5  register-file read address 1 (Rsrc1).
- rf_ra2  out  5  register-file read address 2 (Rsrc2).
- rf_we  out  1  register-file write strobe, one-cycle pulse.
- rf_wa  out  5  register-file write address.
- wb_sel  out  2  write-back source: 0 = imm, 1 = ALU, 2 = dmem read data, 3 = rf port 2 (MOV).
- imm  out  16  latched imm16.
- alu_op  out  5  ALU function: opcode[4:0] for opcodes 0x04..0x10, 0 otherwise.
- dmem_addr  out  8  data-memory address.
- dmem_re  out  1  data-memory read strobe.
- dmem_we  out  1  data-memory write strobe (data is taken from rf port 2).
- busy  out  1  high whenever the state is not IDLE.
- illegal  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Opcode classes:
  - 0x00 LDI: Rdst2 ← imm16.
  - 0x01 MOV: Rdst2 ← R[Rsrc2].
  - 0x02 LOAD: Rdst2 ← dmem[instr[7:0]].
  - 0x03 STORE: dmem[instr[25:18]] ← R[Rsrc2].
  - 0x04..0x10: ALU ops, Rdst1 ← R[Rsrc2] op R[Rsrc1]. These are add, sub, neg, mul, and, or, xor, nand, nor, xnor, not, shl and shr.
  - 0x11..0x3F: illegal.
- States are IDLE, DECODE, EXEC, MULW, MEM and WB.
- IDLE:
  - instr_ready = 1.
  - When instr_valid && instr_ready, latch instr and go to DECODE.
- DECODE:
  - Drive rf_ra1/rf_ra2 from the latched fields; they stay stable until the next accept.
  - LDI/MOV → WB. LOAD/STORE → MEM. ALU ops → EXEC.
  - Illegal → IDLE, with illegal = 1 for this cycle.
- EXEC:
  - alu_op is valid.
  - Opcode 0x07 → MULW. All other ALU ops → WB.
- MULW:
  - Counter loads MUL_LAT−1 on entry and decrements each cycle.
  - At count 0 → WB.
  - alu_op is held for the whole of MULW.
- MEM:
  - LOAD: dmem_re = 1, → WB.
  - STORE: dmem_we = 1, → IDLE (no write-back).
- WB:
  - rf_we = 1 with rf_wa and wb_sel set per class, → IDLE.
  - rf_wa = Rdst2 for LDI/MOV/LOAD and Rdst1 for ALU ops.
- Strobes (rf_we, dmem_re, dmem_we, illegal) are registered and decoded from state. Each is high for exactly one cycle per instruction; they are never high simultaneously.
- Writes to register 0 are issued like any other register; the controller has no special case for it.

## Timing
- Reset:
  - State = IDLE and the latched instruction is cleared.
  - Outputs are 0: rf_we, dmem_re, dmem_we, illegal, busy, alu_op, wb_sel, rf_ra1, rf_ra2, rf_wa, imm, dmem_addr.
  - instr_ready = 0 while rst = 1, and becomes 1 in the first cycle after rst deasserts.
- Reset mid-instruction: abort at the next edge and discard the instruction. No strobe fires after the reset edge.
- Latency per class (accept edge = cycle 0):
  - LDI/MOV: rf_we at cycle 2.
  - ALU (non-mul): rf_we at cycle 3.
  - MUL: rf_we at cycle 3+MUL_LAT.
  - LOAD: dmem_re at cycle 2, rf_we at cycle 3. Memory read data must be valid in the WB cycle.
  - STORE: dmem_we at cycle 2.
  - Illegal: illegal at cycle 1.
- instr_ready returns to 1 the cycle after the last active state.
- Back-to-back throughput: a new instruction can be accepted in the cycle after WB, MEM(store) or DECODE(illegal).
- instr_valid while busy is ignored; fetch must hold the instruction until accepted.
- instr is sampled only on the accept edge; later changes have no effect.

## Test plan
- Reset then LDI: instr 0x0060_1234 (LDI R3, 0x1234) → rf_we pulse at cycle 2, rf_wa = 3, wb_sel = 0, imm = 0x1234, ready high at cycle 3.
- ADD: instr with opcode 0x04, Rdst1 = 7, Rsrc2 = 2, Rsrc1 = 1 → rf_ra2 = 2 and rf_ra1 = 1 from cycle 1, alu_op = 4 at cycle 2, rf_we with rf_wa = 7 and wb_sel = 1 at cycle 3.
- MUL with MUL_LAT = 4: opcode 0x07 → alu_op = 7 held for cycles 2..6, rf_we at cycle 7, busy low at cycle 8.
- LOAD addr 0x5A into R4, then STORE R4 to 0x5A back-to-back with instr_valid held high:
  - LOAD: dmem_re at cycle 2, rf_we at cycle 3 with wb_sel = 2.
  - STORE accepted at cycle 4: dmem_we at cycle 6 with dmem_addr = 0x5A, no rf_we.
- Illegal opcode 0x2A → illegal pulse at cycle 1, no other strobe, ready at cycle 2.
- rst asserted during MULW cycle 4 of a MUL → all outputs 0 the next cycle, no rf_we ever issued, ready 1 after rst drops.

Source files
------------

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl
//
// Multi-cycle issue controller between instruction fetch and a 16-bit datapath.
// Accepts one 32-bit instruction over a valid/ready handshake, latches it, and
// steps through DECODE -> EXEC/MULW/MEM -> WB. Only one instruction is in
// flight at a time.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   instr_valid_i  fetch presents an instruction
//   instr_ready_o  controller can accept an instruction (IDLE and not in reset)
//   instr_i        32-bit instruction word
//   rf_ra1_o       register-file read address 1 (Rsrc1)
//   rf_ra2_o       register-file read address 2 (Rsrc2)
//   rf_we_o        register-file write strobe (one-cycle pulse)
//   rf_wa_o        register-file write address
//   wb_sel_o       write-back source: 0 imm, 1 ALU, 2 dmem, 3 rf port 2
//   imm_o          latched imm16
//   alu_op_o       ALU function (opcode[4:0] for ALU opcodes, else 0)
//   dmem_addr_o    data-memory address
//   dmem_re_o      data-memory read strobe
//   dmem_we_o      data-memory write strobe
//   busy_o         high whenever the controller is not IDLE
//   illegal_o      one-cycle pulse on an undefined opcode

module decode_issue_ctrl #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    output logic [4:0]  rf_ra1_o,
    output logic [4:0]  rf_ra2_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_wa_o,
    output logic [1:0]  wb_sel_o,
    output logic [15:0] imm_o,
    output logic [4:0]  alu_op_o,
    output logic [7:0]  dmem_addr_o,
    output logic        dmem_re_o,
    output logic        dmem_we_o,
    output logic        busy_o,
    output logic        illegal_o
);

    localparam logic [5:0] OpLdi      = 6'h00;
    localparam logic [5:0] OpMov      = 6'h01;
    localparam logic [5:0] OpLoad     = 6'h02;
    localparam logic [5:0] OpStore    = 6'h03;
    localparam logic [5:0] OpAluFirst = 6'h04;
    localparam logic [5:0] OpMul      = 6'h07;
    localparam logic [5:0] OpAluLast  = 6'h10;

    localparam logic [1:0] WbImm = 2'd0;
    localparam logic [1:0] WbAlu = 2'd1;
    localparam logic [1:0] WbMem = 2'd2;
    localparam logic [1:0] WbRf2 = 2'd3;

    // MULW counts MUL_LAT-1 down to 0, so it lasts exactly MUL_LAT cycles.
    localparam logic [3:0] MulCntInit = 4'(MUL_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StMulw,
        StMem,
        StWb
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [3:0]  cnt_q, cnt_d;

    logic rf_we_q, rf_we_d;
    logic dmem_re_q, dmem_re_d;
    logic dmem_we_q, dmem_we_d;
    logic illegal_q, illegal_d;

    logic [5:0] op_q;
    logic [5:0] op_d;
    logic       accept;

    function automatic logic is_alu(input logic [5:0] op);
        return (op >= OpAluFirst) && (op <= OpAluLast);
    endfunction

    function automatic logic is_illegal(input logic [5:0] op);
        return op > OpAluLast;
    endfunction

    assign op_q          = instr_q[31:26];
    assign op_d          = instr_d[31:26];
    assign instr_ready_o = (state_q == StIdle) && !rst_i;
    assign accept        = instr_valid_i && instr_ready_o;

    // Next-state and instruction latch.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    instr_d = instr_i;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (op_q == OpLdi || op_q == OpMov) begin
                    state_d = StWb;
                end else if (op_q == OpLoad || op_q == OpStore) begin
                    state_d = StMem;
                end else if (is_alu(op_q)) begin
                    state_d = StExec;
                end else begin
                    state_d = StIdle;
                end
            end
            StExec: begin
                if (op_q == OpMul) begin
                    state_d = StMulw;
                    cnt_d   = MulCntInit;
                end else begin
                    state_d = StWb;
                end
            end
            StMulw: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWb;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StMem: begin
                state_d = (op_q == OpLoad) ? StWb : StIdle;
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes are decoded from the state being entered and registered, so each
    // is high for exactly the cycle spent in the corresponding state.
    always_comb begin
        rf_we_d   = (state_d == StWb);
        dmem_re_d = (state_d == StMem) && (op_d == OpLoad);
        dmem_we_d = (state_d == StMem) && (op_d == OpStore);
        illegal_d = (state_d == StDecode) && is_illegal(op_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            instr_q   <= 32'd0;
            cnt_q     <= 4'd0;
            rf_we_q   <= 1'b0;
            dmem_re_q <= 1'b0;
            dmem_we_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            rf_we_q   <= rf_we_d;
            dmem_re_q <= dmem_re_d;
            dmem_we_q <= dmem_we_d;
            illegal_q <= illegal_d;
        end
    end

    // Field outputs follow the latched instruction and stay stable until the
    // next accept; reset clears the latch so all of them read zero.
    assign rf_ra1_o  = instr_q[4:0];
    assign rf_ra2_o  = instr_q[9:5];
    assign imm_o     = instr_q[15:0];
    assign alu_op_o  = is_alu(op_q) ? op_q[4:0] : 5'd0;
    assign busy_o    = (state_q != StIdle);
    assign rf_we_o   = rf_we_q;
    assign dmem_re_o = dmem_re_q;
    assign dmem_we_o = dmem_we_q;
    assign illegal_o = illegal_q;

    always_comb begin
        wb_sel_o    = WbImm;
        rf_wa_o     = 5'd0;
        dmem_addr_o = 8'd0;
        if (op_q == OpLdi) begin
            wb_sel_o = WbImm;
            rf_wa_o  = instr_q[25:21];
        end else if (op_q == OpMov) begin
            wb_sel_o = WbRf2;
            rf_wa_o  = instr_q[25:21];
        end else if (op_q == OpLoad) begin
            wb_sel_o    = WbMem;
            rf_wa_o     = instr_q[25:21];
            dmem_addr_o = instr_q[7:0];
        end else if (op_q == OpStore) begin
            dmem_addr_o = instr_q[25:18];
        end else if (is_alu(op_q)) begin
            wb_sel_o = WbAlu;
            rf_wa_o  = instr_q[20:16];
        end
    end

endmodule
